log_mul_div_sched: RTL

- Controller that sequences and shares one log_scale_mul_div unit.
- Phase 1: streams the unit's LUT contents in, LUT_SIZE beats, driving the unit's write port.
- Phase 2: round-robin arbitrates NUM_REQ requesters onto the unit's pipelined datapath and aligns the per-operation mul/div select to the unit's second stage.
- Tags each issued operation through the pipeline and returns the result with the requester ID.

---
 rtl/log_mul_div_sched.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/log_mul_div_sched.sv
`timescale 1ns/1ps
// log_mul_div_sched: streams the LUTs into a shared log_scale_mul_div unit, then arbitrates requesters onto it.
// Define LOG_MUL_DIV_SCHED_STRICT_PRIO_EN for fixed lowest-index priority instead of round-robin.
module log_mul_div_sched #(
  parameter int unsigned FLOAT_LEN = 16,
  parameter int unsigned MANT_LEN  = 10,
  parameter int unsigned LUT_SIZE  = 128,
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned PIPE_LAT  = 2
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           cfg_start,
  input  logic                                           cfg_valid,
  output logic                                           cfg_ready,
  input  logic [MANT_LEN-1:0]                            cfg_log2_data,
  input  logic [FLOAT_LEN-1:0]                           cfg_exp2_data,
  output logic                                           run_ready,
  input  logic [NUM_REQ-1:0]                             req_valid,
  output logic [NUM_REQ-1:0]                             req_ready,
  input  logic [NUM_REQ*FLOAT_LEN-1:0]                   req_a,
  input  logic [NUM_REQ*FLOAT_LEN-1:0]                   req_b,
  input  logic [NUM_REQ-1:0]                             req_op,
  output logic                                           rsp_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [FLOAT_LEN-1:0]                           rsp_data,
  output logic [FLOAT_LEN-1:0]                           u_a,
  output logic [FLOAT_LEN-1:0]                           u_b,
  output logic                                           u_mul_or_div,
  output logic                                           u_lut_wr_en,
  output logic [MANT_LEN-1:0]                            u_log2_data,
  output logic [FLOAT_LEN-1:0]                           u_exp2_data,
  input  logic [FLOAT_LEN-1:0]                           u_result
);
  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT1, RUN, DRAIN} state_t;
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic            op;
  } tag_t;

  state_t              state;
  logic [CNT_W-1:0]    load_cnt;
  tag_t [PIPE_LAT-1:0] tags;
  tag_t                new_tag;
  logic                issue;
  logic                grant_any;
  logic                tags_busy;
  logic                sel_op;
  logic [ID_W-1:0]     grant_id;

`ifndef LOG_MUL_DIV_SCHED_STRICT_PRIO_EN
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;
  logic            hi_hit;
  logic            lo_hit;

  // Lowest valid index above the last grant wins; otherwise wrap to the lowest valid index overall.
  always_comb begin
    hi_id  = '0;
    lo_id  = '0;
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (ID_W'(i) > rr_ptr) begin
          hi_id  = ID_W'(i);
          hi_hit = 1'b1;
        end else begin
          lo_id  = ID_W'(i);
          lo_hit = 1'b1;
        end
      end
    end
    grant_any = hi_hit | lo_hit;
    grant_id  = hi_hit ? hi_id : lo_id;
  end
`else
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
  end
`endif

  assign issue = (state == RUN) && grant_any;

  // Grant vector and operand mux for the selected requester.
  always_comb begin
    req_ready = '0;
    u_a       = '0;
    u_b       = '0;
    sel_op    = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (issue && (grant_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        u_a          = req_a[i*FLOAT_LEN +: FLOAT_LEN];
        u_b          = req_b[i*FLOAT_LEN +: FLOAT_LEN];
        sel_op       = req_op[i];
      end
    end
  end

  always_comb begin
    new_tag     = '0;
    new_tag.vld = issue;
    new_tag.id  = issue ? grant_id : '0;
    new_tag.op  = sel_op;
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int i = 0; i < int'(PIPE_LAT); i++) begin
      tags_busy = tags_busy | tags[i].vld;
    end
  end

  assign u_lut_wr_en  = (state == LOAD) && cfg_valid;
  assign u_log2_data  = u_lut_wr_en ? cfg_log2_data : '0;
  assign u_exp2_data  = u_lut_wr_en ? cfg_exp2_data : '0;
  // The unit consumes mul/div in its second stage, one cycle after operands.
  assign u_mul_or_div = tags[0].vld & tags[0].op;
  assign rsp_valid    = tags[PIPE_LAT-1].vld;
  assign rsp_id       = tags[PIPE_LAT-1].id;
  assign rsp_data     = rsp_valid ? u_result : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      load_cnt  <= '0;
      cfg_ready <= 1'b0;
      run_ready <= 1'b0;
      tags      <= '0;
`ifndef LOG_MUL_DIV_SCHED_STRICT_PRIO_EN
      rr_ptr    <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      for (int i = int'(PIPE_LAT) - 1; i > 0; i--) begin
        tags[i] <= tags[i-1];
      end
      tags[0] <= new_tag;
`ifndef LOG_MUL_DIV_SCHED_STRICT_PRIO_EN
      if (issue) rr_ptr <= grant_id;
`endif
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            cfg_ready <= 1'b1;
            load_cnt  <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            load_cnt <= '0;
          end else if (cfg_valid) begin
            if (load_cnt == CNT_W'(LUT_SIZE - 1)) begin
              state     <= WAIT1;
              cfg_ready <= 1'b0;
              load_cnt  <= '0;
            end else begin
              load_cnt <= load_cnt + CNT_W'(1);
            end
          end
        end
        WAIT1: begin
          state     <= RUN;
          run_ready <= 1'b1;
        end
        RUN: begin
          if (cfg_start) begin
            state     <= DRAIN;
            run_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (!tags_busy) begin
            state     <= LOAD;
            cfg_ready <= 1'b1;
            load_cnt  <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
          run_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
